alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle ops and an iterative shift-add multiplier
//
// Purpose:
//   Accepts one operation at a time via a valid/ready handshake. LOAD, SUM,
//   SUB, AND, XOR, NOT and INC finish on the accept edge. MUL runs an
//   unsigned shift-add over WIDTH further edges. Result and flags sit in one
//   output register and hold until the consumer takes them.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - opcode/a/b present
//   in_ready   - operation can be accepted this cycle
//   opcode     - 0 LOAD, 1 SUM, 2 SUB, 3 AND, 4 XOR, 5 NOT, 6 INC, 7 MUL
//   a, b       - signed operands (MUL treats them as unsigned)
//   out_valid  - result and flags valid
//   out_ready  - consumer takes result this cycle
//   result     - registered operation result
//   overflow, negative, zero, equal, greater, less - flags belonging to result

module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             less
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SUM  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t state, state_nxt;

  logic                 accept;
  logic                 accept_mul;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 cmp_eq, cmp_gt, cmp_lt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  // Accept is possible while the output register is empty or being drained
  // on this same edge.
  assign in_ready   = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign accept_mul = accept && (opcode == OP_MUL);

  // cnt counts completed iterations; the WIDTH-th edge after accept is the last.
  assign mul_last = (state == MUL_RUN) && (cnt == CW'(WIDTH - 1));
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (mul_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_LOAD: alu_res = a;
      OP_SUM: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_INC: begin
        alu_res = a + WIDTH'(1);
        alu_ovf = (a == {1'b0, {(WIDTH-1){1'b1}}});
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Multiplier: multiplicand shifts left, multiplier shifts right, one bit per edge.
  // Comparison flags are taken from the operands at accept and held for the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      cmp_eq <= 1'b0;
      cmp_gt <= 1'b0;
      cmp_lt <= 1'b0;
    end else if (accept_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      cmp_eq <= (a == b);
      cmp_gt <= ($signed(a) > $signed(b));
      cmp_lt <= ($signed(a) < $signed(b));
    end else if (state == MUL_RUN) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // MUL accept never coincides with a pending result: the drain falls through
  // to the out_ready branch, leaving out_valid low for the whole MUL_RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      less      <= 1'b0;
    end else if (accept && !accept_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      overflow  <= alu_ovf;
      negative  <= alu_res[WIDTH-1];
      zero      <= (alu_res == '0);
      equal     <= (a == b);
      greater   <= ($signed(a) > $signed(b));
      less      <= ($signed(a) < $signed(b));
    end else if (mul_last) begin
      out_valid <= 1'b1;
      result    <= acc_step[WIDTH-1:0];
      overflow  <= |acc_step[2*WIDTH-1:WIDTH];
      negative  <= acc_step[WIDTH-1];
      zero      <= (acc_step[WIDTH-1:0] == '0);
      equal     <= cmp_eq;
      greater   <= cmp_gt;
      less      <= cmp_lt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
